control_unit: RTL and testbench

Multi-cycle Moore controller for the 16-bit processor datapath, directly downstream of `instruction_register`. Each cycle it drives that register's `load`, the program-counter controls, data-memory and register-file controls and the ALU select. It uses the registered `instruction` word to sequence fetch, decode and execute for six opcodes.

---
 rtl/processor_pkg.sv | 29 ++
 rtl/control_unit.sv | 100 ++++++++++
 tb/tb_control_unit.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// Shared ISA definitions for the 16-bit processor: opcodes, ALU selects and
// the controller state encoding shown on the debug display.
package processor_pkg;

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

endpackage

// File: rtl/control_unit.sv
// Multi-cycle Moore controller: sequences fetch, decode and execute for the
// six-opcode ISA and drives PC, IR, data-memory, register-file and ALU controls.
module control_unit
    import processor_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] instruction,
    output logic        pc_clr,
    output logic        pc_up,
    output logic        ir_ld,
    output logic [7:0]  d_addr,
    output logic        d_wr,
    output logic        rf_s,
    output logic [3:0]  rf_w_addr,
    output logic        rf_w_en,
    output logic [3:0]  rf_ra_addr,
    output logic [3:0]  rf_rb_addr,
    output logic [2:0]  alu_s,
    output logic [3:0]  state
);

    state_t state_q, state_d;

    // Only DECODE looks at the opcode, so instruction changes elsewhere cannot redirect sequencing.
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_INIT:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (instruction[15:12])
                    OP_NOOP:  state_d = ST_NOOP;
                    OP_STORE: state_d = ST_STORE;
                    OP_LOAD:  state_d = ST_LOAD_A;
                    OP_ADD:   state_d = ST_ADD;
                    OP_SUB:   state_d = ST_SUB;
                    OP_HALT:  state_d = ST_HALT;
                    default:  state_d = ST_NOOP;
                endcase
            end
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode depends only on the state register, so reset forces INIT outputs at once.
    always_comb begin
        pc_clr     = 1'b0;
        pc_up      = 1'b0;
        ir_ld      = 1'b0;
        d_addr     = 8'h00;
        d_wr       = 1'b0;
        rf_s       = 1'b0;
        rf_w_addr  = 4'h0;
        rf_w_en    = 1'b0;
        rf_ra_addr = 4'h0;
        rf_rb_addr = 4'h0;
        alu_s      = ALU_PASS;
        case (state_q)
            ST_INIT: pc_clr = 1'b1;
            ST_FETCH: begin
                ir_ld = 1'b1;
                pc_up = 1'b1;
            end
            // LOAD_A absorbs the synchronous memory read; the register write lands in LOAD_B.
            ST_LOAD_A, ST_LOAD_B: begin
                d_addr    = instruction[11:4];
                rf_s      = 1'b1;
                rf_w_addr = instruction[3:0];
                rf_w_en   = (state_q == ST_LOAD_B);
            end
            ST_STORE: begin
                d_addr     = instruction[7:0];
                rf_ra_addr = instruction[11:8];
                d_wr       = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                rf_ra_addr = instruction[11:8];
                rf_rb_addr = instruction[7:4];
                rf_w_addr  = instruction[3:0];
                rf_w_en    = 1'b1;
                alu_s      = (state_q == ST_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed literal checks followed by randomized
// instruction streams compared every cycle against a cycles-per-instruction model.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] instruction = 16'h0000;
    logic        pc_clr, pc_up, ir_ld, d_wr, rf_s, rf_w_en;
    logic [7:0]  d_addr;
    logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, state;
    logic [2:0]  alu_s;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    control_unit dut (
        .clock      (clock),
        .reset      (reset),
        .instruction(instruction),
        .pc_clr     (pc_clr),
        .pc_up      (pc_up),
        .ir_ld      (ir_ld),
        .d_addr     (d_addr),
        .d_wr       (d_wr),
        .rf_s       (rf_s),
        .rf_w_addr  (rf_w_addr),
        .rf_w_en    (rf_w_en),
        .rf_ra_addr (rf_ra_addr),
        .rf_rb_addr (rf_rb_addr),
        .alu_s      (alu_s),
        .state      (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: position within the current instruction (0 = fetch cycle) plus init/halt flags.
    bit m_init = 1'b1;
    bit m_halt = 1'b0;
    int m_ph   = 0;

    function automatic int cpi(input logic [3:0] op);
        if (op == 4'h2) return 4;
        if (op == 4'h5) return 2;
        return 3;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_init = 1'b1;
            m_halt = 1'b0;
            m_ph   = 0;
        end else if (m_init) begin
            m_init = 1'b0;
            m_ph   = 0;
        end else if (!m_halt) begin
            m_ph++;
            if (m_ph == cpi(instruction[15:12])) begin
                if (instruction[15:12] == 4'h5) m_halt = 1'b1;
                else m_ph = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            logic [3:0]  op;
            bit          run, fet, ex, ld, st, ad, sb;
            logic [3:0]  e_state, e_wa, e_ra, e_rb;
            logic [7:0]  e_da;
            logic [2:0]  e_alu;
            logic [63:0] act, exp;
            op  = instruction[15:12];
            run = !m_init && !m_halt;
            fet = run && (m_ph == 0);
            ex  = run && (m_ph >= 2);
            ld  = ex && (op == 4'h2);
            st  = ex && (op == 4'h1);
            ad  = ex && (op == 4'h3);
            sb  = ex && (op == 4'h4);
            if (m_init)          e_state = 4'd0;
            else if (m_halt)     e_state = 4'd9;
            else if (m_ph == 0)  e_state = 4'd1;
            else if (m_ph == 1)  e_state = 4'd2;
            else if (m_ph == 3)  e_state = 4'd5;
            else if (ld)         e_state = 4'd4;
            else if (st)         e_state = 4'd6;
            else if (ad)         e_state = 4'd7;
            else if (sb)         e_state = 4'd8;
            else                 e_state = 4'd3;
            e_da  = ld ? instruction[11:4] : (st ? instruction[7:0] : 8'h00);
            e_wa  = (ld || ad || sb) ? instruction[3:0] : 4'h0;
            e_ra  = (st || ad || sb) ? instruction[11:8] : 4'h0;
            e_rb  = (ad || sb) ? instruction[7:4] : 4'h0;
            e_alu = ad ? 3'd1 : (sb ? 3'd2 : 3'd0);
            act = {31'd0, pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
                   rf_ra_addr, rf_rb_addr, alu_s, state};
            exp = {31'd0, m_init, fet, fet, e_da, st, ld, e_wa, (ld && m_ph == 3) || ad || sb,
                   e_ra, e_rb, e_alu, e_state};
            check("model_outputs", act, exp);
        end
    end

    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    task automatic wait_fetch();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ir_ld === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_fetch", ok, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        reset = 1'b0;
        instruction = 16'h0000;
        cmp_en = 1'b1;
        tick();
        check("rst_pc_clr", pc_clr, 1'b1);
        check("rst_state", state, 4'd0);
        tick();
        check("rst_ir_ld", ir_ld, 1'b0);
        reset = 1'b1;

        tick();
        check("fetch_state", state, 4'd1);
        check("fetch_ir_ld", ir_ld, 1'b1);
        instruction = 16'h208A;
        tick();
        check("decode_state", state, 4'd2);
        check("decode_ir_ld", ir_ld, 1'b0);
        tick();
        check("load_a_state", state, 4'd4);
        check("load_a_daddr", d_addr, 8'h08);
        check("load_a_waddr", rf_w_addr, 4'hA);
        check("load_a_rf_s", rf_s, 1'b1);
        check("load_a_wen", rf_w_en, 1'b0);
        tick();
        check("load_b_state", state, 4'd5);
        check("load_b_wen", rf_w_en, 1'b1);
        check("load_b_rf_s", rf_s, 1'b1);
        tick();
        check("load_done_fetch", state, 4'd1);

        instruction = 16'h3123;
        tick();
        tick();
        check("add_state", state, 4'd7);
        check("add_fields", {rf_ra_addr, rf_rb_addr, rf_w_addr, 1'b0, alu_s, 3'b000, rf_w_en}, 20'h12311);
        tick();
        check("add_done_fetch", state, 4'd1);

        instruction = 16'h1705;
        tick();
        tick();
        check("store_state", state, 4'd6);
        check("store_daddr", d_addr, 8'h05);
        check("store_ra", rf_ra_addr, 4'h7);
        check("store_dwr", d_wr, 1'b1);
        check("store_wen", rf_w_en, 1'b0);
        tick();
        check("store_dwr_once", d_wr, 1'b0);

        instruction = 16'h4456;
        tick();
        tick();
        check("sub_state", state, 4'd8);
        check("sub_alu", alu_s, 3'd2);
        check("sub_waddr", rf_w_addr, 4'h6);
        tick();

        instruction = 16'hF000;
        tick();
        tick();
        check("noop_state", state, 4'd3);
        tick();
        check("noop_loop", state, 4'd1);

        instruction = 16'h208A;
        tick();
        tick();
        check("mid_load_a", state, 4'd4);
        reset = 1'b0;
        #1;
        check("async_rst_state", state, 4'd0);
        check("async_rst_wen", rf_w_en, 1'b0);
        check("async_rst_pc_clr", pc_clr, 1'b1);
        tick();
        reset = 1'b1;
        tick();
        check("resume_fetch", state, 4'd1);

        instruction = 16'h5000;
        tick();
        tick();
        check("halt_state", state, 4'd9);
        for (int i = 0; i < 21; i++) begin
            tick();
            check("halt_hold", {state, ir_ld, d_wr, rf_w_en, pc_up}, {4'd9, 4'b0000});
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;

        for (int n = 0; n < 300; n++) begin
            wait_fetch();
            op = 4'($urandom_range(0, 15));
            if (op == 4'h5 && $urandom_range(0, 9) != 0) op = 4'h3;
            instruction = {op, 12'($urandom)};
            if (op == 4'h5) begin
                repeat ($urandom_range(2, 6)) tick();
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end else if ($urandom_range(0, 15) == 0) begin
                repeat ($urandom_range(0, 3)) tick();
                reset = 1'b0;
                #1;
                check("rand_async_rst", {state, rf_w_en, d_wr}, 6'd0);
                tick();
                reset = 1'b1;
            end
        end
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
